// File: rtl/seq_max.sv
// seq_max: streaming per-frame maximum, first-argmax and length finder; define SEQ_MAX_SIGNED_EN for signed comparison
module seq_max #(
  parameter int WIDTH = 16,
  parameter int MAX_LEN = 16,
  localparam int IDX_W = ($clog2(MAX_LEN) > 1) ? $clog2(MAX_LEN) : 1,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_cnt
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LEN);
  state_t state_q;
  logic [WIDTH-1:0] max_q, max_d, out_max_q;
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q;
  logic gt, close_d;
  assign in_ready  = state_q != DONE;
  assign out_valid = state_q == DONE;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_cnt   = out_cnt_q;
  // Accumulator values if the presented word is accepted; first word of a frame seeds them
  always_comb begin
`ifdef SEQ_MAX_SIGNED_EN
    gt = $signed(in_data) > $signed(max_q);
`else
    gt = in_data > max_q;
`endif
    max_d   = (state_q == IDLE || gt) ? in_data : max_q;
    idx_d   = (state_q == IDLE) ? '0 : gt ? cnt_q[IDX_W-1:0] : idx_q;
    cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    close_d = in_last || cnt_d == LIMIT;
  end
  // Frame FSM: accumulate beats, latch the result on the closing beat, hold it until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
      out_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (out_ready) state_q <= IDLE;
    end else if (in_valid) begin
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      state_q <= close_d ? DONE : ACC;
      if (close_d) begin
        out_max_q <= max_d;
        out_idx_q <= idx_d;
        out_cnt_q <= cnt_d;
      end
    end
  end
endmodule

// File: tb/tb_seq_max.sv
// tb_seq_max: randomized and directed checks of seq_max against a frame-level reference model
module tb_seq_max;
  localparam int M = 16;
  typedef struct packed {
    logic [15:0] m;
    logic [3:0]  i;
    logic [4:0]  c;
  } res_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready;
  logic [15:0] in_data = '0, out_max;
  logic [3:0] out_idx;
  logic [4:0] out_cnt;
  int total = 0, bad = 0;
  bit auto_rdy = 1, rand_rdy = 0;
  res_t got_q[$], exp_q[$];
  logic [15:0] cur[$];

  seq_max #(.WIDTH(16), .MAX_LEN(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  // Consumer: decides out_ready for the coming edge and records every result handshake
  initial begin
    out_ready = 0;
    forever begin
      @(negedge clk);
      out_ready = auto_rdy && (!rand_rdy || $urandom_range(0, 3) != 0);
      if (out_valid && out_ready && !rst) got_q.push_back(res_t'{out_max, out_idx, out_cnt});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  function automatic bit more(input logic [15:0] a, input logic [15:0] b);
`ifdef SEQ_MAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic res_t ref_frame(input logic [15:0] q[$]);
    int b = 0;
    for (int k = 1; k < q.size(); k++) if (more(q[k], q[b])) b = k;
    return '{q[b], 4'(b), 5'(q.size())};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l, input int gap);
    int n = 0;
    bit close;
    in_valid = 0;
    repeat (gap) tick();
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    cur.push_back(d);
    close = l || cur.size() == M;
    if (close) begin
      exp_q.push_back(ref_frame(cur));
      cur.delete();
    end
    tick();
    in_valid = 0;
    total++;
    if (out_valid !== close) begin
      bad++;
      $display("FAIL beat_out_valid: out_valid=%0b required %0b", out_valid, close);
    end
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b need 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b need 0", out_valid); end
    if (out_max !== 16'd0) begin bad++; $display("FAIL rst_out_max: got %0h need 0", out_max); end
    if (out_idx !== 4'd0) begin bad++; $display("FAIL rst_out_idx: got %0d need 0", out_idx); end
    if (out_cnt !== 5'd0) begin bad++; $display("FAIL rst_out_cnt: got %0d need 0", out_cnt); end
    rst = 0;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: in_ready=%0b out_valid=%0b need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    res_t want[3];
    want[0] = '{16'd20, 4'd1, 5'd2};
    want[1] = '{16'd40, 4'd0, 5'd2};
    want[2] = '{16'd5, 4'd0, 5'd3};
    got_q.delete(); exp_q.delete(); auto_rdy = 1; rand_rdy = 0;
    send(16'd10, 0, 0); send(16'd20, 1, 0);
    send(16'd40, 0, 1); send(16'd30, 1, 0);
    send(16'd5, 0, 0); send(16'd5, 0, 0); send(16'd5, 1, 0);
    wait_results(3);
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL basic_count: got %0d results need 3", got_q.size());
    end else for (int k = 0; k < 3; k++) begin
      total++;
      if (got_q[k] !== want[k]) begin
        bad++;
        $display("FAIL basic_%0d: got max=%0d idx=%0d cnt=%0d need max=%0d idx=%0d cnt=%0d",
                 k, got_q[k].m, got_q[k].i, got_q[k].c, want[k].m, want[k].i, want[k].c);
      end
    end
  endtask

  task automatic test_maxlen();
    res_t want[2];
    want[0] = '{16'd15, 4'd15, 5'd16};
    want[1] = '{16'd19, 4'd3, 5'd4};
    got_q.delete(); exp_q.delete(); auto_rdy = 1; rand_rdy = 0;
    for (int k = 0; k < 20; k++) send(16'(k), k == 19, 0);
    wait_results(2);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL maxlen_count: got %0d results need 2", got_q.size());
    end else for (int k = 0; k < 2; k++) begin
      total++;
      if (got_q[k] !== want[k]) begin
        bad++;
        $display("FAIL maxlen_%0d: got max=%0d idx=%0d cnt=%0d need max=%0d idx=%0d cnt=%0d",
                 k, got_q[k].m, got_q[k].i, got_q[k].c, want[k].m, want[k].i, want[k].c);
      end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete(); auto_rdy = 0; rand_rdy = 0;
    send(16'd100, 0, 0); send(16'd50, 1, 0);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_max !== 16'd100 || out_idx !== 4'd0 || out_cnt !== 5'd2) begin
        bad++;
        $display("FAIL hold_%0d: in_ready=%0b out_valid=%0b max=%0d idx=%0d cnt=%0d need 0 1 100 0 2",
                 k, in_ready, out_valid, out_max, out_idx, out_cnt);
      end
      tick();
    end
    auto_rdy = 1;
    tick();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_handshake: out_valid=%0b need 1", out_valid); end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_max !== 16'd100) begin
      bad++;
      $display("FAIL release: in_ready=%0b out_valid=%0b max=%0d need 1 0 100", in_ready, out_valid, out_max);
    end
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL release_count: got %0d need 1", got_q.size()); end
  endtask

  task automatic test_mid_reset();
    got_q.delete(); exp_q.delete(); auto_rdy = 1; rand_rdy = 0;
    send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 0, 0);
    rst = 1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_max !== 16'd0 || out_idx !== 4'd0 || out_cnt !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset: in_ready=%0b out_valid=%0b max=%0d idx=%0d cnt=%0d need 1 0 0 0 0",
               in_ready, out_valid, out_max, out_idx, out_cnt);
    end
    tick();
    rst = 0;
    cur.delete(); got_q.delete(); exp_q.delete();
    tick();
    send(16'd7, 1, 0);
    wait_results(1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== res_t'{16'd7, 4'd0, 5'd1}) begin
      bad++;
      $display("FAIL after_reset: got %0d results first=%0h need max=7 idx=0 cnt=1", got_q.size(), got_q.size() ? got_q[0] : '0);
    end
  endtask

  task automatic test_sign();
    res_t want;
`ifdef SEQ_MAX_SIGNED_EN
    want = '{16'd3, 4'd1, 5'd2};
`else
    want = '{16'hFFFF, 4'd0, 5'd2};
`endif
    got_q.delete(); exp_q.delete(); auto_rdy = 1; rand_rdy = 0;
    send(16'hFFFF, 0, 0); send(16'd3, 1, 0);
    wait_results(1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      bad++;
      $display("FAIL sign: got %0d results first=%0h need %0h", got_q.size(), got_q.size() ? got_q[0] : '0, want);
    end
  endtask

  task automatic test_random();
    got_q.delete(); exp_q.delete(); auto_rdy = 1; rand_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 20);
      bit narrow = $urandom_range(0, 1) != 0;
      for (int j = 0; j < len; j++)
        send(narrow ? 16'($urandom_range(0, 3)) : 16'($urandom), j == len - 1, $urandom_range(0, 2));
    end
    wait_results(exp_q.size());
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d results need %0d", got_q.size(), exp_q.size());
    end else for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL random_%0d: got max=%0h idx=%0d cnt=%0d need max=%0h idx=%0d cnt=%0d",
                 k, got_q[k].m, got_q[k].i, got_q[k].c, exp_q[k].m, exp_q[k].i, exp_q[k].c);
      end
    end
    rand_rdy = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_maxlen();
    test_backpressure();
    test_mid_reset();
    test_sign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_max.md
# seq_max

Streaming, parametrised maximum finder: accepts a frame of WIDTH-bit words over a valid/ready input, tracks the running maximum and its position, and presents the frame maximum, its index and the frame length on a valid/ready output. It generalises the two-operand combinational comparator to arbitrary width, variable-length frames, argmax and flow control. It sits between a data producer and any consumer needing per-frame peak values.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- MAX_LEN, 16, maximum elements per frame (≥2); frame is force-closed at this count
- IDX_W (localparam), max($clog2(MAX_LEN),1), index width
- CNT_W (localparam), $clog2(MAX_LEN+1), count width

- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  input word
- in_last  in  1  accepted word is the last of its frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_max  out  WIDTH  maximum of the frame
- out_idx  out  IDX_W  0-based position of the first occurrence of the maximum
- out_cnt  out  CNT_W  number of words in the frame (1..MAX_LEN)

## Operation
- States: IDLE (no word of current frame yet), ACC (≥1 word accepted), DONE (result held).
- Beat accepted when in_valid && in_ready; in_ready = (state != DONE).
- IDLE, beat: max←in_data, idx←0, cnt←1; → DONE if in_last or MAX_LEN==1-equivalent cnt limit reached, else → ACC.
- ACC, beat: if in_data > max (strict) then max←in_data, idx←cnt; cnt←cnt+1; → DONE if in_last or cnt+1 == MAX_LEN, else stay.
- Ties keep earlier index (strict greater-than only).
- DONE: out_valid=1, outputs stable; on out_ready → IDLE. in_data/in_last ignored in DONE.
- Frame reaching MAX_LEN without in_last is closed; the next accepted word starts a new frame. in_last on the MAX_LEN-th word closes the same single frame (no empty frame).
- Comparison unsigned by default (see Configuration).
- in_valid low in IDLE/ACC: hold state indefinitely; no timeout.

## Timing
- Reset (async, any state including mid-frame): state=IDLE, out_valid=0, out_max=0, out_idx=0, out_cnt=0, in_ready=1 as soon as rst asserts; partial frame discarded.
- in_ready and out_valid are decoded from registered state only (no combinational path from in_valid/out_ready).
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: one word per cycle within a frame; minimum one cycle of in_ready=0 per frame (DONE lasts ≥1 cycle); new frame's first beat accepted earliest the cycle after out handshake.
- out_* registers change only on beats and reset; values remain after DONE exits until overwritten by next closing beat (out_valid qualifies them).

## Configuration
- SEQ_MAX_SIGNED_EN: defined → in_data/max compared as two's-complement signed WIDTH-bit values; undefined → unsigned comparison. No port or timing difference.

## Test plan
- Frame {10, 20} with in_last on 20 → out_max=20, out_idx=1, out_cnt=2, out_valid one cycle after last beat.
- Frame {40, 30} → out_max=40, out_idx=0, out_cnt=2; then {5,5,5} → out_max=5, out_idx=0 (first occurrence), out_cnt=3.
- MAX_LEN=16, 20 words 0..19 with in_last only on word 19 → first result max=15, idx=15, cnt=16; second result max=19, idx=3, cnt=4.
- Hold out_ready=0 for 5 cycles after DONE → in_ready=0 and outputs stable throughout; out_ready=1 → IDLE next cycle, in_ready=1.
- Assert rst after 3 words of a frame → outputs zero, in_ready=1 immediately; following frame {7} → max=7, idx=0, cnt=1.
- WIDTH=16, frame {0xFFFF, 3}: without SEQ_MAX_SIGNED_EN → max=0xFFFF, idx=0; with it → max=3, idx=1.
